sprite_sequencer: RTL

SPRITE_SEQUENCER -- requirements
Module: sprite_sequencer

---
 rtl/genius_pkg.sv | 44 ++++
 rtl/sprite_sequencer_if.sv | 23 ++
 rtl/cmd_fifo.sv | 54 +++++
 rtl/sprite_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared definitions for the sprite sequencer: command field widths, sprite
// bit indices, FSM state encoding, the packed command payload and a helper
// that turns a sprite index into its one-hot flag pattern.
package genius_pkg;

  localparam int unsigned SPRITE_W    = 3;
  localparam int unsigned ON_W        = 6;
  localparam int unsigned GAP_W       = 4;
  localparam int unsigned CMD_W       = SPRITE_W + ON_W + GAP_W;
  localparam int unsigned CNT_W       = 6;
  localparam int unsigned NUM_SPRITES = 6;
  localparam int unsigned FLAGS_W     = 7;

  localparam int unsigned BIT_BLUE   = 0;
  localparam int unsigned BIT_GREEN  = 1;
  localparam int unsigned BIT_RED    = 2;
  localparam int unsigned BIT_YELLOW = 3;
  localparam int unsigned BIT_LOSE   = 4;
  localparam int unsigned BIT_WIN    = 5;
  localparam int unsigned BIT_POWER  = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [SPRITE_W-1:0] sprite;
    logic [ON_W-1:0]     on_frames;
    logic [GAP_W-1:0]    gap_frames;
  } cmd_t;

  // Indices 6 and 7 are silent commands and map to no flag.
  function automatic logic [NUM_SPRITES-1:0] sprite_onehot(input logic [SPRITE_W-1:0] s);
    logic [NUM_SPRITES-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      oh[i] = (32'(s) == i);
    end
    return oh;
  endfunction

endpackage

// File: rtl/sprite_sequencer_if.sv
// Command handshake bundle between a command source and the sprite sequencer.
//   CMD_VALID  command offered (master)
//   CMD_READY  sequencer queue not full (slave)
//   CMD_SPRITE sprite index, CMD_ON lit frames, CMD_GAP dark frames (master)
interface sprite_sequencer_if import genius_pkg::*; ();

  logic                CMD_VALID;
  logic                CMD_READY;
  logic [SPRITE_W-1:0] CMD_SPRITE;
  logic [ON_W-1:0]     CMD_ON;
  logic [GAP_W-1:0]    CMD_GAP;

  modport master (
    output CMD_VALID, CMD_SPRITE, CMD_ON, CMD_GAP,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID, CMD_SPRITE, CMD_ON, CMD_GAP,
    output CMD_READY
  );

endinterface

// File: rtl/cmd_fifo.sv
// Synchronous show-ahead FIFO holding queued sprite commands.
//   VGA_CLK, RESET  clock and synchronous active-high reset
//   push/din        write when not full
//   pop             drop head when not empty; dout always shows the head
//   flush           empty the queue (wins over push/pop)
//   full, empty     occupancy status
module cmd_fifo import genius_pkg::*; #(
  parameter int unsigned WIDTH = CMD_W,
  parameter int unsigned DEPTH = 8
) (
  input  logic             VGA_CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Pointer update
  always_ff @(posedge VGA_CLK) begin
    if (RESET || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage
  always_ff @(posedge VGA_CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/sprite_sequencer.sv
// Plays queued sprite commands against the VGA frame timebase: each command
// lights one sprite flag for CMD_ON frames, then stays dark for CMD_GAP frames.
//   VGA_CLK, RESET  pixel clock, synchronous active-high reset
//   VGA_VS          active-low vertical sync, frame tick source
//   cmd             command handshake (slave side)
//   PWR_ON          power-sprite request, mirrored on SPRITES_FLAGS[6]
//   FLUSH           abort current command and empty the queue
//   SPRITES_FLAGS   sprite enables to the VGA controller
//   BUSY            sequencing or commands pending
//   SEQ_DONE        one-cycle pulse when the last queued command finishes
module sprite_sequencer import genius_pkg::*; #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               VGA_CLK,
  input  logic               RESET,
  input  logic               VGA_VS,
  sprite_sequencer_if.slave  cmd,
  input  logic               PWR_ON,
  input  logic               FLUSH,
  output logic [FLAGS_W-1:0] SPRITES_FLAGS,
  output logic               BUSY,
  output logic               SEQ_DONE
);

  seq_state_t             state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d;
  cmd_t                   cur, cur_d;
  cmd_t                   cmd_in;
  cmd_t                   fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   advance;
  logic                   done_d;
  logic [NUM_SPRITES-1:0] flags_d;
  logic [CNT_W-1:0]       on_last;
  logic [CNT_W-1:0]       gap_last;
  logic                   vs_q;
  logic                   tick;

  assign cmd_in        = {cmd.CMD_SPRITE, cmd.CMD_ON, cmd.CMD_GAP};
  assign cmd.CMD_READY = !fifo_full;
  // A command offered alongside FLUSH is discarded.
  assign push          = cmd.CMD_VALID && !fifo_full && !FLUSH;
  assign BUSY          = (state != ST_IDLE) || !fifo_empty;

  // Final count of each phase; CMD_ON of 0 behaves as 1.
  assign on_last  = (cur.on_frames == '0) ? '0 : CNT_W'(cur.on_frames) - CNT_W'(1);
  assign gap_last = CNT_W'(cur.gap_frames) - CNT_W'(1);

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .VGA_CLK (VGA_CLK),
    .RESET   (RESET),
    .push    (push),
    .pop     (pop),
    .flush   (FLUSH),
    .din     (cmd_in),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state, counter and flag decode
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cur_d   = cur;
    pop     = 1'b0;
    advance = 1'b0;
    done_d  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          cur_d   = fifo_dout;
          cnt_d   = '0;
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (tick) begin
          if (cnt == on_last) begin
            if (cur.gap_frames != '0) begin
              state_d = ST_GAP;
              cnt_d   = '0;
            end else begin
              advance = 1'b1;
            end
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (cnt == gap_last) advance = 1'b1;
          else                 cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Chain straight into the next command so no dead cycle appears.
    if (advance) begin
      if (!fifo_empty) begin
        pop     = 1'b1;
        cur_d   = fifo_dout;
        cnt_d   = '0;
        state_d = ST_ON;
      end else begin
        cnt_d   = '0;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end

    if (FLUSH) begin
      pop     = 1'b0;
      cnt_d   = '0;
      done_d  = 1'b0;
      state_d = ST_IDLE;
    end

    flags_d = (state_d == ST_ON) ? sprite_onehot(cur_d.sprite) : '0;
  end

  // State, frame tick and output registers
  always_ff @(posedge VGA_CLK) begin
    if (RESET) begin
      vs_q          <= 1'b1;
      tick          <= 1'b0;
      state         <= ST_IDLE;
      cnt           <= '0;
      cur           <= '0;
      SPRITES_FLAGS <= '0;
      SEQ_DONE      <= 1'b0;
    end else begin
      vs_q          <= VGA_VS;
      tick          <= vs_q && !VGA_VS;
      state         <= state_d;
      cnt           <= cnt_d;
      cur           <= cur_d;
      SPRITES_FLAGS <= {PWR_ON, flags_d};
      SEQ_DONE      <= done_d;
    end
  end

endmodule
